// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the CPU <-> UART core byte bridge.
// Feature macro used by the bridge: UART_BRIDGE_OVF_CNT_EN.
package uart_bridge_pkg;

  localparam int DEPTH_LOG2_DEF = 4;
  localparam int OVF_CNT_W = 8;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_HOLD
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ACK,
    R_GUARD
  } rx_state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO, first-word fall-through head.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push,
  input  logic                pop,
  input  logic [7:0]          din,
  output logic [7:0]          head,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0] wp;
  logic [DEPTH_LOG2:0] rp;
  logic [7:0]          mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  assign empty = wp == rp;
  assign full  = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                 (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);

  // A pop in the same cycle frees a slot, so a push on full still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign level = wp - rp;
  assign head  = mem[rp[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + PTR_ONE;
      if (do_pop)  rp <= rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// TX/RX byte FIFOs between the CPU UART port and the uart core.
// Define UART_BRIDGE_OVF_CNT_EN to get the saturating drop counter.
module uart_fifo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           cpu_tx_data,
  input  logic                 cpu_tx_we,
  output logic                 cpu_tx_busy,
  input  logic                 cpu_rx_re,
  output logic [7:0]           cpu_rx_data,
  output logic                 cpu_rx_valid,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_we,
  input  logic                 uart_tx_busy,
  input  logic [7:0]           uart_rx_data,
  input  logic                 uart_rx_valid,
  output logic                 uart_rx_re,
  output logic                 rx_ovf,
  input  logic                 rx_ovf_clr,
  output logic [OVF_CNT_W-1:0] rx_ovf_cnt,
  output logic [DEPTH_LOG2:0]  tx_level,
  output logic [DEPTH_LOG2:0]  rx_level
);

  tx_state_t  tx_st;
  tx_state_t  tx_nx;
  rx_state_t  rx_st;
  rx_state_t  rx_nx;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] rx_head;
  logic       drop;

  sync_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cpu_tx_we),
    .pop   (uart_tx_we),
    .din   (cpu_tx_data),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (uart_rx_re),
    .pop   (cpu_rx_re),
    .din   (uart_rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign cpu_tx_busy  = tx_full;
  assign cpu_rx_valid = !rx_empty;
  assign cpu_rx_data  = rx_empty ? 8'h00 : rx_head;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_st <= T_IDLE;
      rx_st <= R_IDLE;
    end else begin
      tx_st <= tx_nx;
      rx_st <= rx_nx;
    end
  end

  // T_HOLD waits out the core's busy latency after a write.
  always_comb begin
    tx_nx        = tx_st;
    uart_tx_we   = 1'b0;
    uart_tx_data = 8'h00;
    unique case (tx_st)
      T_IDLE: if (!tx_empty && !uart_tx_busy) tx_nx = T_LOAD;
      T_LOAD: begin
        uart_tx_we   = 1'b1;
        uart_tx_data = tx_head;
        tx_nx        = T_HOLD;
      end
      T_HOLD:  tx_nx = T_IDLE;
      default: tx_nx = T_IDLE;
    endcase
  end

  // R_GUARD masks a still-high valid so one byte is taken once.
  always_comb begin
    rx_nx      = rx_st;
    uart_rx_re = 1'b0;
    unique case (rx_st)
      R_IDLE: if (uart_rx_valid) rx_nx = R_ACK;
      R_ACK: begin
        uart_rx_re = 1'b1;
        rx_nx      = R_GUARD;
      end
      R_GUARD: rx_nx = R_IDLE;
      default: rx_nx = R_IDLE;
    endcase
  end

  assign drop = uart_rx_re && rx_full && !cpu_rx_re;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_ovf <= 1'b0;
    end else if (drop) begin
      rx_ovf <= 1'b1;
    end else if (rx_ovf_clr) begin
      rx_ovf <= 1'b0;
    end
  end

`ifdef UART_BRIDGE_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt;

  // A drop coinciding with a clear counts as the first drop after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_cnt <= '0;
    end else if (rx_ovf_clr) begin
      ovf_cnt <= {{(OVF_CNT_W-1){1'b0}}, drop};
    end else if (drop && ovf_cnt != '1) begin
      ovf_cnt <= ovf_cnt + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rx_ovf_cnt = ovf_cnt;
`else
  assign rx_ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomised bench for uart_fifo_bridge against a queue-based model.
// Honours UART_BRIDGE_OVF_CNT_EN for the expected drop count.
module tb_uart_fifo_bridge;

  localparam int DL = 4;
  localparam int D  = 1 << DL;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    cpu_tx_data = '0;
  logic          cpu_tx_we = 1'b0;
  logic          cpu_tx_busy;
  logic          cpu_rx_re = 1'b0;
  logic [7:0]    cpu_rx_data;
  logic          cpu_rx_valid;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_we;
  logic          uart_tx_busy = 1'b0;
  logic [7:0]    uart_rx_data = '0;
  logic          uart_rx_valid = 1'b0;
  logic          uart_rx_re;
  logic          rx_ovf;
  logic          rx_ovf_clr = 1'b0;
  logic [7:0]    rx_ovf_cnt;
  logic [DL:0]   tx_level;
  logic [DL:0]   rx_level;

  always #5 clk = ~clk;

  uart_fifo_bridge #(
    .DEPTH_LOG2(DL)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_tx_we    (cpu_tx_we),
    .cpu_tx_busy  (cpu_tx_busy),
    .cpu_rx_re    (cpu_rx_re),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .uart_tx_data (uart_tx_data),
    .uart_tx_we   (uart_tx_we),
    .uart_tx_busy (uart_tx_busy),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_re   (uart_rx_re),
    .rx_ovf       (rx_ovf),
    .rx_ovf_clr   (rx_ovf_clr),
    .rx_ovf_cnt   (rx_ovf_cnt),
    .tx_level     (tx_level),
    .rx_level     (rx_level)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_tx_obs = 0;
  int n_rx_obs = 0;

  // Model: byte queues plus strobe spacing (one strobe per 3 cycles).
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit tx_go;
  bit rx_go;
  bit m_ovf;
  int m_cnt;
  int cyc;
  int last_tx;
  int last_rx;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    tx_go = 0;
    rx_go = 0;
    m_ovf = 0;
    m_cnt = 0;
    last_tx = cyc - 10;
    last_rx = cyc - 10;
  endtask

  task automatic compare();
    n_tx_obs += int'(uart_tx_we);
    n_rx_obs += int'(uart_rx_re);
    check("uart_tx_we", uart_tx_we, tx_go);
    if (tx_go) check("uart_tx_data", uart_tx_data, txq[0]);
    check("cpu_tx_busy", cpu_tx_busy, txq.size() == D);
    check("tx_level", tx_level, txq.size());
    check("uart_rx_re", uart_rx_re, rx_go);
    check("cpu_rx_valid", cpu_rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) check("cpu_rx_data", cpu_rx_data, rxq[0]);
    check("rx_level", rx_level, rxq.size());
    check("rx_ovf", rx_ovf, m_ovf);
    check("rx_ovf_cnt", rx_ovf_cnt, m_cnt);
  endtask

  task automatic update();
    int  tsz;
    int  rsz;
    bit  nt;
    bit  nr;
    bit  drop;
    tsz = txq.size();
    rsz = rxq.size();
    nt = !tx_go && (last_tx != cyc - 1) && tsz > 0 && !uart_tx_busy;
    nr = !rx_go && (last_rx != cyc - 1) && uart_rx_valid;
    if (tx_go) begin
      void'(txq.pop_front());
      last_tx = cyc;
    end
    if (cpu_tx_we && txq.size() < D) txq.push_back(cpu_tx_data);
    drop = 0;
    if (cpu_rx_re && rsz > 0) void'(rxq.pop_front());
    if (rx_go) begin
      last_rx = cyc;
      if (rxq.size() < D) rxq.push_back(uart_rx_data);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (rx_ovf_clr) m_ovf = 0;
`ifdef UART_BRIDGE_OVF_CNT_EN
    if (rx_ovf_clr) m_cnt = int'(drop);
    else if (drop && m_cnt < 255) m_cnt++;
`endif
    tx_go = nt;
    rx_go = nr;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    update();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_rx();
    cpu_rx_re = 1'b1;
    repeat (D + 4) step();
    cpu_rx_re = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    uart_rx_data = b;
    uart_rx_valid = 1'b1;
    step();
    uart_rx_valid = 1'b0;
    step();
    step();
  endtask

  logic [7:0] seq3 [3];
  int exp_cnt;
  int k;

  initial begin
    seq3[0] = 8'h41;
    seq3[1] = 8'h42;
    seq3[2] = 8'h43;
    cyc = 0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      compare();
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;

    // three TX bytes, 3-cycle strobe spacing
    n_tx_obs = 0;
    for (int i = 0; i < 3; i++) begin
      cpu_tx_data = seq3[i];
      cpu_tx_we = 1'b1;
      step();
    end
    cpu_tx_we = 1'b0;
    repeat (12) step();
    check("tx_pulses3", n_tx_obs, 3);
    check("tx_level_back0", tx_level, 0);

    // TX fill while core busy
    uart_tx_busy = 1'b1;
    repeat (3) step();
    n_tx_obs = 0;
    for (int i = 0; i < D + 1; i++) begin
      cpu_tx_data = 8'($urandom);
      cpu_tx_we = 1'b1;
      step();
    end
    cpu_tx_we = 1'b0;
    repeat (2) step();
    check("tx_full_level", tx_level, D);
    check("tx_full_busy", cpu_tx_busy, 1);
    check("tx_no_strobe", n_tx_obs, 0);
    uart_tx_busy = 1'b0;
    repeat (3 * D + 6) step();
    check("tx_drained", tx_level, 0);

    // stuck rx_valid gives one capture per 3 cycles
    n_rx_obs = 0;
    uart_rx_data = 8'h5A;
    uart_rx_valid = 1'b1;
    repeat (10) step();
    uart_rx_valid = 1'b0;
    repeat (4) step();
    check("rx_stuck_caps", n_rx_obs, 4);
    check("rx_stuck_data", cpu_rx_data, 8'h5A);
    drain_rx();

    // RX overflow, then pop-in-ACK rescue
    for (int i = 0; i < D; i++) rx_pulse(8'($urandom));
    rx_pulse(8'hEE);
    check("ovf_set", rx_ovf, 1);
`ifdef UART_BRIDGE_OVF_CNT_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    check("ovf_cnt_one", rx_ovf_cnt, exp_cnt);
    rx_ovf_clr = 1'b1;
    step();
    rx_ovf_clr = 1'b0;
    step();
    uart_rx_data = 8'hEE;
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_rx_re = rx_go;
      step();
      uart_rx_valid = 1'b0;
    end
    cpu_rx_re = 1'b0;
    check("rescue_no_ovf", rx_ovf, 0);
    check("rescue_level", rx_level, D);
    drain_rx();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cpu_tx_we = ($urandom % 3) == 0;
      cpu_tx_data = 8'($urandom);
      uart_tx_busy = ($urandom % 4) == 0;
      uart_rx_valid = ($urandom % 2) == 0;
      uart_rx_data = 8'($urandom);
      cpu_rx_re = ($urandom % 4) == 0;
      rx_ovf_clr = ($urandom % 50) == 0;
      step();
    end
    cpu_tx_we = 1'b0;
    uart_tx_busy = 1'b0;
    cpu_rx_re = 1'b0;
    rx_ovf_clr = 1'b0;

    // 300+ drops: counter saturates
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      uart_rx_data = 8'($urandom);
      step();
    end
    uart_rx_valid = 1'b0;
    repeat (3) step();
`ifdef UART_BRIDGE_OVF_CNT_EN
    exp_cnt = 255;
`else
    exp_cnt = 0;
`endif
    check("ovf_cnt_sat", rx_ovf_cnt, exp_cnt);
    check("ovf_sticky", rx_ovf, 1);
    rx_ovf_clr = 1'b1;
    step();
    rx_ovf_clr = 1'b0;
    step();
    check("clr_ovf", rx_ovf, 0);
    check("clr_cnt", rx_ovf_cnt, 0);

    // refill and overflow, then reset while in T_LOAD
    uart_rx_valid = 1'b1;
    repeat (60) step();
    uart_rx_valid = 1'b0;
    repeat (3) step();
    check("ovf_again", rx_ovf, 1);
    cpu_tx_data = 8'h77;
    cpu_tx_we = 1'b1;
    step();
    cpu_tx_we = 1'b0;
    k = 0;
    while (!tx_go && k < 20) begin
      step();
      k++;
    end
    #2;
    check("load_before_rst", uart_tx_we, 1);
    rstn = 1'b0;
    #1;
    check("rst_tx_we", uart_tx_we, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_rx_valid", cpu_rx_valid, 0);
    check("rst_ovf", rx_ovf, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    repeat (5) step();
    check("post_rst_tx", tx_level, 0);
    check("post_rst_rx", rx_level, 0);
    check("post_rst_ovf", rx_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
